// File: rtl/blob_bbox.sv
// Bounding box and population tracker for a single-bit raster mask stream.
// Publishes one registered result set per frame with a one-cycle valid pulse.
module blob_bbox #(
  parameter int unsigned CW = 32
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic [15:0]   width,
  input  logic [15:0]   height,
  input  logic          restart,
  input  logic          in_write,
  input  logic          in_pixel,
  output logic          out_valid,
  output logic          out_found,
  output logic [15:0]   out_xmin,
  output logic [15:0]   out_xmax,
  output logic [15:0]   out_ymin,
  output logic [15:0]   out_ymax,
  output logic [CW-1:0] out_count
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t        state;
  logic [15:0]   wr, hr, x, y;
  logic          acc_found;
  logic [15:0]   acc_xmin, acc_xmax, acc_ymin, acc_ymax;
  logic [CW-1:0] acc_count;

  logic [15:0]   cur_x, cur_y, cur_w, cur_h;
  logic          accept, hit, x_end, last;
  logic          n_found;
  logic [15:0]   n_xmin, n_xmax, n_ymin, n_ymax;
  logic [CW-1:0] n_count;

  // The first pixel of a frame is seen in IDLE: it sits at (0,0) and uses
  // the live width/height, so a 1x1 frame can complete on that same edge.
  always_comb begin
    cur_x   = (state == ACTIVE) ? x  : '0;
    cur_y   = (state == ACTIVE) ? y  : '0;
    cur_w   = (state == ACTIVE) ? wr : width;
    cur_h   = (state == ACTIVE) ? hr : height;
    accept  = in_write && !restart &&
              ((state == ACTIVE) || ((width != '0) && (height != '0)));
    hit     = accept && in_pixel;
    x_end   = (cur_x == cur_w - 16'd1);
    last    = x_end && (cur_y == cur_h - 16'd1);
    n_found = acc_found | hit;
    n_xmin  = (hit && (cur_x < acc_xmin)) ? cur_x : acc_xmin;
    n_xmax  = (hit && (cur_x > acc_xmax)) ? cur_x : acc_xmax;
    n_ymin  = (hit && (cur_y < acc_ymin)) ? cur_y : acc_ymin;
    n_ymax  = (hit && (cur_y > acc_ymax)) ? cur_y : acc_ymax;
    n_count = (hit && (acc_count != '1)) ? acc_count + CW'(1) : acc_count;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      wr        <= '0;
      hr        <= '0;
      x         <= '0;
      y         <= '0;
      acc_found <= 1'b0;
      acc_xmin  <= '1;
      acc_xmax  <= '0;
      acc_ymin  <= '1;
      acc_ymax  <= '0;
      acc_count <= '0;
      out_valid <= 1'b0;
      out_found <= 1'b0;
      out_xmin  <= '0;
      out_xmax  <= '0;
      out_ymin  <= '0;
      out_ymax  <= '0;
      out_count <= '0;
    end else begin
      out_valid <= 1'b0;
      if (restart || (accept && last)) begin
        // Both abandon and completion return to a clean IDLE; only the
        // completion path publishes.
        state     <= IDLE;
        x         <= '0;
        y         <= '0;
        acc_found <= 1'b0;
        acc_xmin  <= '1;
        acc_xmax  <= '0;
        acc_ymin  <= '1;
        acc_ymax  <= '0;
        acc_count <= '0;
        if (!restart) begin
          out_valid <= 1'b1;
          out_found <= n_found;
          out_xmin  <= n_found ? n_xmin : '0;
          out_xmax  <= n_found ? n_xmax : '0;
          out_ymin  <= n_found ? n_ymin : '0;
          out_ymax  <= n_found ? n_ymax : '0;
          out_count <= n_count;
        end
      end else if (accept) begin
        state     <= ACTIVE;
        acc_found <= n_found;
        acc_xmin  <= n_xmin;
        acc_xmax  <= n_xmax;
        acc_ymin  <= n_ymin;
        acc_ymax  <= n_ymax;
        acc_count <= n_count;
        if (state == IDLE) begin
          wr <= width;
          hr <= height;
        end
        if (x_end) begin
          x <= '0;
          y <= cur_y + 16'd1;
        end else begin
          x <= cur_x + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_blob_bbox.sv
// Self-checking bench for blob_bbox: directed frame table, hand sequences for
// restart/reset/stall cases, and randomized frames against a frame-buffer model.
module tb_blob_bbox;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] width = '0, height = '0;
  logic        restart = 1'b0, in_write = 1'b0, in_pixel = 1'b0;

  logic        out_valid, out_found;
  logic [15:0] out_xmin, out_xmax, out_ymin, out_ymax;
  logic [31:0] out_count;
  logic        v3, f3;
  logic [15:0] xmin3, xmax3, ymin3, ymax3;
  logic [2:0]  count3;

  blob_bbox #(.CW(32)) dut (
    .clock(clock), .reset_n(reset_n), .width(width), .height(height),
    .restart(restart), .in_write(in_write), .in_pixel(in_pixel),
    .out_valid(out_valid), .out_found(out_found),
    .out_xmin(out_xmin), .out_xmax(out_xmax),
    .out_ymin(out_ymin), .out_ymax(out_ymax), .out_count(out_count)
  );

  blob_bbox #(.CW(3)) dut3 (
    .clock(clock), .reset_n(reset_n), .width(width), .height(height),
    .restart(restart), .in_write(in_write), .in_pixel(in_pixel),
    .out_valid(v3), .out_found(f3),
    .out_xmin(xmin3), .out_xmax(xmax3),
    .out_ymin(ymin3), .out_ymax(ymax3), .out_count(count3)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: buffers the frame's pixels and derives the result from
  // pixel indices when the frame is complete.
  bit          m_active = 0;
  int          m_w = 0, m_h = 0;
  bit          m_q[$];
  bit          e_valid = 0, e_found = 0;
  int          e_xmin = 0, e_xmax = 0, e_ymin = 0, e_ymax = 0;
  longint      e_count = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic publish();
    bit f = 0;
    int xl = 65535, xh = 0, yl = 65535, yh = 0;
    longint c = 0;
    for (int i = 0; i < m_q.size(); i++) begin
      if (m_q[i]) begin
        int px = i % m_w;
        int py = i / m_w;
        f = 1;
        c++;
        if (px < xl) xl = px;
        if (px > xh) xh = px;
        if (py < yl) yl = py;
        if (py > yh) yh = py;
      end
    end
    e_valid = 1;
    e_found = f;
    e_xmin  = f ? xl : 0;
    e_xmax  = f ? xh : 0;
    e_ymin  = f ? yl : 0;
    e_ymax  = f ? yh : 0;
    e_count = c;
    m_active = 0;
  endtask

  task automatic model_step();
    e_valid = 0;
    if (!reset_n) begin
      m_active = 0;
      m_q.delete();
      e_found = 0; e_xmin = 0; e_xmax = 0; e_ymin = 0; e_ymax = 0; e_count = 0;
    end else if (restart) begin
      m_active = 0;
      m_q.delete();
    end else if (in_write) begin
      if (!m_active && width != 0 && height != 0) begin
        m_active = 1;
        m_w = int'(width);
        m_h = int'(height);
        m_q.delete();
      end
      if (m_active) begin
        m_q.push_back(in_pixel);
        if (longint'(m_q.size()) == longint'(m_w) * longint'(m_h)) publish();
      end
    end
  endtask

  // One clock: apply inputs, advance the model, sample #1 after the edge.
  task automatic cyc(input bit we, input bit pix);
    in_write = we;
    in_pixel = pix;
    model_step();
    @(posedge clock);
    #1;
    chk("valid", out_valid, e_valid);
    chk("found", out_found, e_found);
    chk("xmin", out_xmin, e_xmin);
    chk("xmax", out_xmax, e_xmax);
    chk("ymin", out_ymin, e_ymin);
    chk("ymax", out_ymax, e_ymax);
    chk("count", out_count, (e_count > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : e_count);
    chk("valid3", v3, e_valid);
    chk("count3", count3, (e_count > 7) ? 7 : e_count);
    chk("xmax3", xmax3, e_xmax);
    in_write = 0;
    in_pixel = 0;
  endtask

  task automatic expect_pulse(input string name, input bit f, input int xl, input int xh,
                              input int yl, input int yh, input int c);
    chk({name, ".valid"}, out_valid, 1);
    chk({name, ".found"}, out_found, f);
    chk({name, ".xmin"}, out_xmin, xl);
    chk({name, ".xmax"}, out_xmax, xh);
    chk({name, ".ymin"}, out_ymin, yl);
    chk({name, ".ymax"}, out_ymax, yh);
    chk({name, ".count"}, out_count, c);
    chk({name, ".count3"}, count3, (c > 7) ? 7 : c);
  endtask

  typedef struct {
    string       name;
    int          w, h;
    logic [63:0] pat;
    bit          f;
    int          xl, xh, yl, yh, c;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{"zeros4x3",  4, 3, 64'h0,    0, 0, 0, 0, 0, 0};
    vecs[1] = '{"three4x3",  4, 3, 64'h842,  1, 1, 3, 0, 2, 3};
    vecs[2] = '{"ones2x2",   2, 2, 64'hF,    1, 0, 1, 0, 1, 4};
    vecs[3] = '{"one1x1",    1, 1, 64'h1,    1, 0, 0, 0, 0, 1};
    vecs[4] = '{"ones4x4",   4, 4, 64'hFFFF, 1, 0, 3, 0, 3, 16};
    vecs[5] = '{"tail3x1",   3, 1, 64'h4,    1, 2, 2, 0, 0, 1};

    // Reset state
    cyc(0, 0);
    cyc(0, 0);
    reset_n = 1;
    cyc(0, 0);

    // Zero-sized geometry: the pixel is ignored
    width = 0; height = 3;
    cyc(1, 1);
    cyc(1, 1);

    for (int v = 0; v < 6; v++) begin
      width  = 16'(vecs[v].w);
      height = 16'(vecs[v].h);
      for (int i = 0; i < vecs[v].w * vecs[v].h; i++) cyc(1, vecs[v].pat[i]);
      expect_pulse(vecs[v].name, vecs[v].f, vecs[v].xl, vecs[v].xh,
                   vecs[v].yl, vecs[v].yh, vecs[v].c);
      cyc(0, 0);
    end

    // Stalls plus a width change mid-frame; next frame picks up width 8
    begin
      logic [11:0] pat = 12'h842;
      int stall_at[5];
      for (int k = 0; k < 5; k++) stall_at[k] = $urandom_range(1, 11);
      width = 4; height = 3;
      for (int i = 0; i < 12; i++) begin
        for (int k = 0; k < 5; k++) if (stall_at[k] == i) cyc(0, 0);
        if (i == 5) width = 8;
        cyc(1, pat[i]);
      end
      expect_pulse("stall4x3", 1, 1, 3, 0, 2, 3);
      height = 1;
      for (int i = 0; i < 8; i++) cyc(1, i == 7);
      expect_pulse("wide8x1", 1, 7, 7, 0, 0, 1);
    end

    // Restart together with pixel 7, then a 2x2 all-ones frame
    width = 4; height = 3;
    for (int i = 0; i < 6; i++) cyc(1, 1);
    restart = 1;
    cyc(1, 1);
    restart = 0;
    chk("restart.hold_xmin", out_xmin, 7);
    cyc(0, 0);
    width = 2; height = 2;
    for (int i = 0; i < 4; i++) cyc(1, 1);
    expect_pulse("after_restart", 1, 0, 1, 0, 1, 4);

    // Reset mid-frame, then a 1x1 frame
    width = 4; height = 3;
    for (int i = 0; i < 3; i++) cyc(1, 1);
    reset_n = 0;
    cyc(1, 1);
    chk("reset.count", out_count, 0);
    chk("reset.xmax", out_xmax, 0);
    cyc(0, 0);
    reset_n = 1;
    width = 1; height = 1;
    cyc(1, 1);
    expect_pulse("post_reset1x1", 1, 0, 0, 0, 0, 1);
    cyc(0, 0);

    // Randomized frames: stalls, geometry changes, occasional restart
    for (int fr = 0; fr < 60; fr++) begin
      int w = $urandom_range(1, 6);
      int h = $urandom_range(1, 4);
      int dens = $urandom_range(0, 4);
      int rs_at = ($urandom_range(0, 9) == 0) ? $urandom_range(0, w * h - 1) : -1;
      width = 16'(w); height = 16'(h);
      for (int i = 0; i < w * h; i++) begin
        while ($urandom_range(0, 3) == 0) cyc(0, $urandom_range(0, 1));
        if ($urandom_range(0, 7) == 0) begin
          width = 16'($urandom_range(0, 7));
          height = 16'($urandom_range(0, 5));
        end
        restart = (i == rs_at);
        cyc(1, $urandom_range(0, 4) < dens);
        restart = 0;
      end
      for (int k = 0; k < 4 && m_active; k++) begin
        width = 16'(w); height = 16'(h);
        cyc(1, $urandom_range(0, 1));
      end
      restart = 1;
      cyc(0, 0);
      restart = 0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/blob_bbox.md
Name: blob_bbox

Overview:
- Downstream consumer of the binary morphology stages (erosion/dilation) in the camera image-processing chain.
- Takes the single-bit cleaned mask stream in raster order (in_write/in_pixel, wired to the upstream out_read/out_pixel) and tracks the bounding box and population of set pixels over each frame.
- At frame end it publishes one registered result set with a single-cycle valid pulse, for the HPS/Avalon readout logic.
- Multi-channel masks use one instance per mask bit.

Parameters:
- CW, 32, width of out_count; the accumulator saturates at 2^CW-1.

Ports:
- clock  input  1  system clock; all logic on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- width  input  16  image width in pixels; sampled at frame start.
- height  input  16  image height in lines; sampled at frame start.
- restart  input  1  synchronous pulse; abandons the current frame and resynchronises to pixel (0,0).
- in_write  input  1  pixel strobe, one pixel per asserted cycle.
- in_pixel  input  1  mask value (1 = object).
- out_valid  output  1  one-cycle pulse: new result on out_*.
- out_found  output  1  1 if at least one set pixel in the last frame.
- out_xmin, out_xmax  output  16  column bounds of set pixels.
- out_ymin, out_ymax  output  16  line bounds of set pixels.
- out_count  output  CW  number of set pixels, saturating.

Behaviour:
- Reset: all outputs 0, state IDLE, x=y=0, accumulators cleared.
- Accumulator clear values: found=0, xmin=ymin=16'hFFFF, xmax=ymax=0, count=0.

State IDLE (no pixel of the current frame seen yet):
- in_write=1: latch width/height into wr/hr, treat the pixel as (0,0), go to ACTIVE.
- If wr==0 or hr==0, the pixel is ignored and the state stays IDLE.

State ACTIVE:
- Each in_write advances x.
- At x==wr-1: x wraps to 0 and y increments.
- At x==wr-1 and y==hr-1 the pixel is the last of the frame.

Per accepted pixel with in_pixel=1:
- found<=1.
- xmin/xmax/ymin/ymax updated with the current x,y, including the last pixel.
- count+1, saturating at all ones.

Frame end (last pixel accepted on edge k):
- On edge k, out_* load the final accumulator values, including the last pixel's contribution.
- out_valid=1 for exactly the cycle after edge k.
- Accumulators clear, x=y=0, state returns to IDLE.
- A 1x1 frame completes on its first pixel.
- If found=0, the out_x*/out_y* registers load 0, not the sentinel values.

Holding and stalls:
- out_* hold their values until the next frame end.
- out_valid is 0 at all other times.
- in_write=0 cycles freeze all counters (stalls allowed anywhere in the frame).

restart:
- On any edge with restart=1: accumulators clear, x=y=0, state IDLE, no out_valid.
- restart has priority over a simultaneous in_write; that pixel is dropped.
- out_* keep the previous frame's result.

Other rules:
- Changes to width/height during ACTIVE have no effect until the next IDLE sampling.
- Reset asserted mid-frame: immediate return to the reset values; no partial result is ever published.
- Comparisons are unsigned, 16-bit; width is at most 65535.

Test Plan:
- width=4, height=3, all pixels 0, continuous in_write -> out_valid pulse on the cycle after pixel 12; found=0, all coordinates 0, count=0.
- width=4, height=3, only (1,0), (3,2) and (2,1) set -> xmin=1, xmax=3, ymin=0, ymax=2, count=3, found=1. The pulse appears on the cycle after pixel 12 even when pixel 12 is (3,2).
- Same 4x3 frame with 5 random idle cycles inserted between pixels, then width changed to 8 mid-frame -> identical result. The next frame uses width 8.
- restart asserted at pixel 7 together with in_write, then a full 2x2 all-ones frame -> no pulse for the aborted frame; the next pulse gives a 0..1 box with count=4. Previous out_* are held meanwhile.
- CW=3, 4x4 all-ones frame -> out_count=7 (saturated), box 0..3.
- reset_n low mid-frame, then a 1x1 frame with pixel=1 -> outputs are 0 during reset; the pulse follows the single pixel with count=1 and the box at (0,0).
